// File: rtl/lag_window_pkg.sv
// Shared constants, state encoding, lag-window ROM tables and ITU basic
// operators (L_mult, mult, L_mac) used by the lag-window stage.
package lag_window_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned M      = 10;

    localparam logic [ADDR_W-1:0] AUTOCORR_R   = 11'd64;
    localparam logic [ADDR_W-1:0] LAG_WINDOW_R = 11'd320;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        CALC  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic signed [33:0] MAX32 = 34'sd2147483647;
    localparam logic signed [33:0] MIN32 = -34'sd2147483648;
    localparam logic signed [16:0] MAX16 = 17'sd32767;
    localparam logic signed [16:0] MIN16 = -17'sd32768;

    // High halves of the lag window, one entry per r[1..10].
    function automatic logic signed [HALF_W-1:0] lag_h(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return 16'sd32728;
            4'd1:    return 16'sd32619;
            4'd2:    return 16'sd32438;
            4'd3:    return 16'sd32187;
            4'd4:    return 16'sd31867;
            4'd5:    return 16'sd31480;
            4'd6:    return 16'sd31029;
            4'd7:    return 16'sd30517;
            4'd8:    return 16'sd29946;
            4'd9:    return 16'sd29321;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [HALF_W-1:0] lag_l(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    return 16'sd11904;
            4'd1:    return 16'sd17280;
            4'd2:    return 16'sd30720;
            4'd3:    return 16'sd25856;
            4'd4:    return 16'sd24192;
            4'd5:    return 16'sd28992;
            4'd6:    return 16'sd24384;
            4'd7:    return 16'sd7360;
            4'd8:    return 16'sd19520;
            4'd9:    return 16'sd14784;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sat32(input logic signed [33:0] x);
        if (x > MAX32) return 32'sh7FFF_FFFF;
        if (x < MIN32) return 32'sh8000_0000;
        return x[DATA_W-1:0];
    endfunction

    function automatic logic signed [HALF_W-1:0] sat16(input logic signed [16:0] x);
        if (x > MAX16) return 16'sh7FFF;
        if (x < MIN16) return 16'sh8000;
        return x[HALF_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] l_mult(input logic signed [HALF_W-1:0] a,
                                                        input logic signed [HALF_W-1:0] b);
        logic signed [33:0] p;
        p = 34'(a) * 34'(b);
        return sat32(p <<< 1);
    endfunction

    function automatic logic signed [HALF_W-1:0] mult(input logic signed [HALF_W-1:0] a,
                                                      input logic signed [HALF_W-1:0] b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        return sat16(17'(p >>> 15));
    endfunction

    function automatic logic signed [DATA_W-1:0] l_mac(input logic signed [DATA_W-1:0] acc,
                                                       input logic signed [HALF_W-1:0] a);
        return sat32(34'(acc) + (34'(a) <<< 1));
    endfunction

endpackage

// File: rtl/lag_window_mpy32.sv
// Combinational double-precision Mpy_32 built from the ITU basic operators.
module lag_mpy32
    import lag_window_pkg::*;
(
    input  logic signed [HALF_W-1:0] hi1,
    input  logic signed [HALF_W-1:0] lo1,
    input  logic signed [HALF_W-1:0] hi2,
    input  logic signed [HALF_W-1:0] lo2,
    output logic signed [DATA_W-1:0] prod_c
);

    logic signed [DATA_W-1:0] acc0;
    logic signed [DATA_W-1:0] acc1;

    always_comb begin
        acc0   = l_mult(hi1, hi2);
        acc1   = l_mac(acc0, mult(hi1, lo2));
        prod_c = l_mac(acc1, mult(lo1, hi2));
    end

endmodule

// File: rtl/lag_window.sv
// Lag-window stage: reads r[0..10], windows r[1..10] with Mpy_32, writes back.
module lag_window
    import lag_window_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] readAddr,
    input  logic [DATA_W-1:0] memIn,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] memOut,
    output logic              memWrite
);

    state_t                   state;
    logic [IDX_W-1:0]         i;
    logic [DATA_W-1:0]        r_reg;
    logic [IDX_W-1:0]         tab_idx;
    logic signed [DATA_W-1:0] mpy_c;
    logic [DATA_W-1:0]        result_c;

    // i-1 wraps to 15 for r[0]; the ROMs return 0 there and the result is bypassed.
    assign tab_idx = i - 4'd1;

    lag_mpy32 u_mpy (
        .hi1    (r_reg[31:16]),
        .lo1    ({1'b0, r_reg[15:1]}),
        .hi2    (lag_h(tab_idx)),
        .lo2    (lag_l(tab_idx)),
        .prod_c (mpy_c)
    );

    assign result_c = (i == '0) ? r_reg : mpy_c;

    // Read address is registered on entry to READ so the RAM sees it for the whole cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            i         <= '0;
            r_reg     <= '0;
            done      <= 1'b0;
            memWrite  <= 1'b0;
            readAddr  <= '0;
            writeAddr <= '0;
            memOut    <= '0;
        end else begin
            memWrite <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i        <= '0;
                        done     <= 1'b0;
                        readAddr <= AUTOCORR_R;
                        state    <= READ;
                    end
                end
                READ: state <= LATCH;
                LATCH: begin
                    r_reg <= memIn;
                    state <= CALC;
                end
                CALC: begin
                    memOut    <= result_c;
                    writeAddr <= LAG_WINDOW_R + ADDR_W'(i);
                    memWrite  <= 1'b1;
                    state     <= WRITE;
                end
                WRITE: begin
                    if (i == IDX_W'(M)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i        <= i + 4'd1;
                        readAddr <= AUTOCORR_R + ADDR_W'(i + 4'd1);
                        state    <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/lag_window.md
Name: lag_window

Overview:
- Downstream neighbour of the autocorrelation stage in the G.729 LPC analysis chain.
- Runs after autocorrelation signals done: reads r[0..10] (32-bit, normalized) from the shared scratch memory.
- Applies the G.729 lag window to r[1..10] using double-precision Mpy_32 arithmetic, with r[0] passed through unchanged.
- Writes the 11 windowed values back to memory, ready for Levinson-Durbin.

Parameters:
- AUTOCORR_R, from paramList, base address of the r[0..10] input array (11-bit).
- LAG_WINDOW_R, from paramList, base address of the windowed output array (11-bit).
- M, 10, LPC order; the block processes M+1 coefficients.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- start  in  1  one-cycle pulse that begins processing. Ignored while busy.
- done  out  1  high once all 11 writes complete. Held until the next accepted start or reset.
- readAddr  out  11  memory read address.
- memIn  in  32  memory read data. Synchronous RAM: valid on the cycle after readAddr is presented.
- writeAddr  out  11  memory write address.
- memOut  out  32  memory write data.
- memWrite  out  1  memory write enable, one cycle per coefficient.

Behaviour:
- Reset values (reset=0 at a clk edge): state=IDLE, i=0, done=0, memWrite=0, readAddr=0, writeAddr=0, memOut=0. Reset mid-operation aborts immediately; memory writes already made remain.
- States: IDLE, READ, LATCH, CALC, WRITE, DONE.
- IDLE: wait for start=1. On start: i<=0, done<=0, go to READ.
- DONE: same as IDLE; done stays 1 until start.
- READ: readAddr=AUTOCORR_R+i; go to LATCH.
- LATCH: rReg<=memIn; go to CALC.
- CALC: compute the result (see Arithmetic); resReg<=result; go to WRITE.
- WRITE: writeAddr=LAG_WINDOW_R+i, memOut=resReg, memWrite=1 for exactly this cycle.
  - If i==M: go to DONE and set done<=1 on this edge, so done is high the cycle after the last write.
  - Else i<=i+1 and go to READ.
- Latency: 4 cycles per coefficient, 44 cycles from the start edge to the final write. done is high 45 cycles after start is sampled.
- start while busy (any state other than IDLE or DONE) is ignored; no restart.
- The write-enable and read address are never active in the same cycle as a write to the same address. In-place use (LAG_WINDOW_R==AUTOCORR_R) is legal.
- Arithmetic for i=0: result = rReg, unchanged.
- Arithmetic for i>=1, with lh=LAG_H[i-1], ll=LAG_L[i-1] (ROM tables in the package):
  - Split: rh=rReg[31:16] (signed), rl=rReg[15:1] zero-extended to 16 bits (L_Extract).
  - result = L_mac(L_mac(L_mult(rh,lh), mult(rh,ll), 1), mult(rl,lh), 1).
  - L_mult(a,b) = sat32(2*a*b).
  - mult(a,b) = sat16((a*b)>>>15).
  - L_mac(acc,a,1) = sat32(acc + 2*a).
  - All saturation is to signed 32-bit / 16-bit limits, bit-exact with the ITU basic operators.
- LAG_H = 32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321.
- LAG_L = 11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784.

Decomposition:
- Shared package (paramList): AUTOCORR_R, LAG_WINDOW_R, M, the LAG_H/LAG_L constant tables, and the state encodings.
- One natural sub-module: lag_mpy32. It is combinational Mpy_32 (hi1, lo1, hi2, lo2 -> 32-bit) built from the existing L_mult, mult and L_mac operator blocks.
- The FSM, index counter and address generation live in lag_window.

Test Plan:
- Reset held low mid-run (at cycle 20 after start) -> memWrite=0, done=0 next cycle. A subsequent start completes a full 44-cycle pass.
- Memory r[0..10] all 0x00010000 -> out[0]=0x00010000; out[1]=0x0000FFB0 (2*32728); out[10]=0x0000E512 (2*29321). done high exactly 45 cycles after start.
- r[1]=0x7FFFFFFF -> out[1]=0x7FD85CFC. r[0]=0x7FFFFFFF -> out[0]=0x7FFFFFFF.
- r all zero -> all 11 outputs 0. Exactly 11 memWrite pulses at addresses LAG_WINDOW_R..+10, ascending.
- start pulsed again at cycle 10 while busy -> ignored. Timing is identical to a single start; done is held until the next start after DONE.
- Full regression: feed the autocorrelation-stage outputs from the ITU G.729 test vectors (120 frames) -> bit-exact match against the reference lag-windowed r vectors, with the same CORRECT/ERROR reporting as the autocorrelation bench.
